// File: rtl/cmd_pkg.sv
// Shared opcodes, response bytes and state encodings for the command executor
// and its response register.
package cmd_pkg;

  localparam logic [7:0] OP_WRITE    = 8'h00;
  localparam logic [7:0] OP_READ     = 8'h01;
  localparam logic [7:0] OP_BURST    = 8'h02;

  localparam logic [7:0] ERR_BAD_CMD = 8'h04;
  localparam logic [7:0] ERR_OVERRUN = 8'h05;
  localparam logic [7:0] RSP_ACK     = 8'h06;

  typedef enum logic [2:0] {
    IDLE, CHECK, MEM_REQ, MEM_WAIT, TX, TX_WAIT, SEND_ACK, SEND_ERR
  } state_e;

  typedef enum logic [1:0] {
    RSP_SRC_NONE, RSP_SRC_BYTE, RSP_SRC_WORD
  } resp_src_e;

endpackage

// File: rtl/resp_mux.sv
// Response payload register: loads an error/ack byte or a read word for the
// transmitter and keeps it steady until the next response is loaded.
module resp_mux
  import cmd_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  resp_src_e         src,
  input  logic [7:0]        byte_in,
  input  logic [DATA_W-1:0] word_in,
  output logic              tx_mode,
  output logic [7:0]        tx_byte,
  output logic [DATA_W-1:0] tx_word
);

  logic              mode_d, mode_q;
  logic [7:0]        byte_d, byte_q;
  logic [DATA_W-1:0] word_d, word_q;

  // NOTE: every variable gets a default before the branches so no latch is inferred.
  always_comb begin
    mode_d = mode_q;
    byte_d = byte_q;
    word_d = word_q;
    case (src)
      RSP_SRC_BYTE: begin
        mode_d = 1'b0;
        byte_d = byte_in;
      end
      RSP_SRC_WORD: begin
        mode_d = 1'b1;
        word_d = word_in;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      byte_q <= '0;
      word_q <= '0;
    end else begin
      mode_q <= mode_d;
      byte_q <= byte_d;
      word_q <= word_d;
    end
  end

  assign tx_mode = mode_q;
  assign tx_byte = byte_q;
  assign tx_word = word_q;

endmodule

// File: rtl/cmd_executor.sv
// Executes decoded write/read/burst-read commands against the SRAM and hands
// every response (read word, ack or error byte) to the transmitter one at a time.
module cmd_executor
  import cmd_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2,
  parameter int MAX_BURST   = 16,
  parameter int ACK_WRITES  = 1
) (
  input  logic              sys_clk,
  input  logic              sw_0,
  input  logic              cmd_valid,
  input  logic [7:0]        cmd_opcode,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [1:0]        cmd_error,
  output logic              mem_enable,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              tx_start,
  output logic              tx_mode,
  output logic [7:0]        tx_byte,
  output logic [DATA_W-1:0] tx_word,
  input  logic              tx_done,
  output logic              busy
);

  localparam logic [2:0] WAIT_LAST = 3'(MEM_LATENCY - 1);
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  state_e            state_d, state_q;
  logic [7:0]        op_d, op_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [1:0]        cerr_d, cerr_q;
  logic [7:0]        count_d, count_q;
  logic [2:0]        wait_d, wait_q;
  logic              rw_d, rw_q;
  logic              ovr_d, ovr_q;

  logic       chk_send, chk_ovr_clr, chk_rw;
  logic [7:0] chk_byte, chk_count;
  resp_src_e  rsp_src;
  logic [7:0] rsp_byte;
  logic       wait_done;

  assign wait_done = (wait_q == WAIT_LAST);

  // Outcome of the CHECK state, evaluated in priority order.
  always_comb begin
    chk_send    = 1'b1;
    chk_ovr_clr = 1'b0;
    chk_rw      = 1'b1;
    chk_byte    = ERR_BAD_CMD;
    chk_count   = 8'd1;
    if (cerr_q != 2'b00) begin
      chk_byte = {6'b0, cerr_q};
    end else if (ovr_q) begin
      chk_byte    = ERR_OVERRUN;
      chk_ovr_clr = 1'b1;
    end else begin
      case (op_q)
        OP_WRITE: begin
          chk_send = 1'b0;
          chk_rw   = 1'b0;
        end
        OP_READ: chk_send = 1'b0;
        OP_BURST: begin
          if (data_q[7:0] != 8'd0 && data_q[7:0] <= BURST_MAX) begin
            chk_send  = 1'b0;
            chk_count = data_q[7:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sw_0) begin
    if (!sw_0) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (cmd_valid) state_d = CHECK;
      CHECK:    state_d = chk_send ? SEND_ERR : MEM_REQ;
      MEM_REQ: begin
        if (rw_q)                 state_d = MEM_WAIT;
        else if (ACK_WRITES != 0) state_d = SEND_ACK;
        else                      state_d = IDLE;
      end
      MEM_WAIT: if (wait_done) state_d = TX;
      SEND_ACK, SEND_ERR: state_d = TX;
      TX:       state_d = TX_WAIT;
      // Only a word response belongs to a (burst) read that may need another beat.
      TX_WAIT:  if (tx_done) state_d = (tx_mode && count_q != 8'd1) ? MEM_REQ : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_enable = (state_q == MEM_REQ);
    tx_start   = (state_q == TX);
    busy       = (state_q != IDLE);
    rsp_src    = RSP_SRC_NONE;
    rsp_byte   = chk_byte;
    if (state_q == CHECK && chk_send) begin
      rsp_src = RSP_SRC_BYTE;
    end else if (state_q == SEND_ACK) begin
      rsp_src  = RSP_SRC_BYTE;
      rsp_byte = RSP_ACK;
    end else if (state_q == MEM_WAIT && wait_done) begin
      rsp_src = RSP_SRC_WORD;
    end
  end

  always_comb begin
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cerr_d  = cerr_q;
    count_d = count_q;
    wait_d  = wait_q;
    rw_d    = rw_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_opcode;
          addr_d = cmd_addr;
          data_d = cmd_data;
          cerr_d = cmd_error;
        end
      end
      CHECK: begin
        rw_d    = chk_rw;
        count_d = chk_count;
        if (chk_ovr_clr) ovr_d = 1'b0;
      end
      MEM_REQ:  wait_d = '0;
      MEM_WAIT: wait_d = wait_q + 3'd1;
      TX_WAIT: begin
        if (tx_done && tx_mode) begin
          count_d = count_q - 8'd1;
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase
    // A new overrun wins over the clear in CHECK so it is never lost.
    if (cmd_valid && state_q != IDLE) ovr_d = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sw_0) begin
    if (!sw_0) begin
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cerr_q  <= '0;
      count_q <= '0;
      wait_q  <= '0;
      rw_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cerr_q  <= cerr_d;
      count_q <= count_d;
      wait_q  <= wait_d;
      rw_q    <= rw_d;
      ovr_q   <= ovr_d;
    end
  end

  assign mem_rw    = rw_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;

  resp_mux #(.DATA_W(DATA_W)) u_resp_mux (
    .clk     (sys_clk),
    .rst_n   (sw_0),
    .src     (rsp_src),
    .byte_in (rsp_byte),
    .word_in (mem_rdata),
    .tx_mode (tx_mode),
    .tx_byte (tx_byte),
    .tx_word (tx_word)
  );

endmodule

// File: tb/tb_cmd_executor.sv
// Bench for cmd_executor: SRAM and transmitter models around the DUT, and a
// command-level reference model whose expected transactions are compared every cycle.
module tb_cmd_executor;

  localparam int AW  = 15;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int MAX_BURST = 16;

  logic          sys_clk = 1'b0;
  logic          sw_0;
  logic          cmd_valid;
  logic [7:0]    cmd_opcode;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [1:0]    cmd_error;
  logic          mem_enable, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          tx_start, tx_mode;
  logic [7:0]    tx_byte;
  logic [DW-1:0] tx_word;
  logic          tx_done;
  logic          busy;

  cmd_executor #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .MAX_BURST(MAX_BURST), .ACK_WRITES(1)) dut (
    .sys_clk(sys_clk), .sw_0(sw_0), .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_error(cmd_error),
    .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .tx_start(tx_start), .tx_mode(tx_mode), .tx_byte(tx_byte),
    .tx_word(tx_word), .tx_done(tx_done), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct { logic rw; logic [AW-1:0] addr; logic [DW-1:0] wdata; } mem_op_t;
  typedef struct { logic mode; logic [7:0] b; logic [DW-1:0] w; } tx_t;

  mem_op_t exp_mem[$];
  tx_t     exp_tx[$];
  logic [DW-1:0] sram    [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [0:LAT-1];
  bit m_ovr = 0;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // SRAM: writes land at the edge, read data appears LAT cycles after the request.
  always @(posedge sys_clk) begin
    if (mem_enable && !mem_rw) sram[mem_addr] <= mem_wdata;
    rd_pipe[0] <= (mem_enable && mem_rw) ? sram[mem_addr] : DW'($urandom);
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Reference model: the full list of transactions one accepted command must produce.
  task automatic push_byte(input logic [7:0] b);
    exp_tx.push_back('{mode: 1'b0, b: b, w: '0});
  endtask

  task automatic model_cmd(input logic [7:0] op, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [1:0] err);
    int len;
    logic [AW-1:0] a;
    if (err != 2'b00) push_byte({6'b0, err});
    else if (m_ovr) begin
      push_byte(8'h05);
      m_ovr = 0;
    end else if (op == 8'h00) begin
      exp_mem.push_back('{rw: 1'b0, addr: addr, wdata: data});
      ref_mem[addr] = data;
      push_byte(8'h06);
    end else if (op == 8'h01 || op == 8'h02) begin
      len = (op == 8'h01) ? 1 : int'(data[7:0]);
      if (len == 0 || len > MAX_BURST) push_byte(8'h04);
      else for (int i = 0; i < len; i++) begin
        a = addr + AW'(i);
        exp_mem.push_back('{rw: 1'b1, addr: a, wdata: '0});
        exp_tx.push_back('{mode: 1'b1, b: '0, w: ref_mem[a]});
      end
    end else push_byte(8'h04);
  endtask

  // Transmitter model plus the per-cycle compare process.
  bit   tx_busy = 0, tx_auto = 1, force_done = 0;
  int   tx_cnt = 0;
  tx_t  cur, et;
  mem_op_t em;
  int   men_count = 0, txs_count = 0;
  int   first_men_cyc = -1, first_txs_cyc = -1;
  logic         last_tx_mode;
  logic [7:0]   last_tx_byte;
  logic [DW-1:0] last_tx_word;
  logic [AW-1:0] seen_addr[$];

  always @(negedge sys_clk) begin
    if (!sw_0) begin
      tx_busy = 0;
      tx_done = 1'b0;
    end else begin
      if (tx_busy) begin
        check("tx_hold_mode", 64'(tx_mode), 64'(cur.mode));
        if (cur.mode) check("tx_hold_word", 64'(tx_word), 64'(cur.w));
        else          check("tx_hold_byte", 64'(tx_byte), 64'(cur.b));
      end
      tx_done = 1'b0;
      if (force_done) tx_done = 1'b1;
      else if (tx_auto) begin
        if (tx_busy) begin
          if (tx_cnt == 0) begin
            tx_done = 1'b1;
            tx_busy = 0;
          end else tx_cnt--;
        end else if ($urandom_range(0, 9) == 0) tx_done = 1'b1;  // stray pulse
      end
      if (mem_enable) begin
        men_count++;
        seen_addr.push_back(mem_addr);
        if (first_men_cyc < 0) first_men_cyc = cyc;
        if (exp_mem.size() == 0) check("mem_unexpected", 64'(mem_enable), 64'd0);
        else begin
          em = exp_mem.pop_front();
          check("mem_rw", 64'(mem_rw), 64'(em.rw));
          check("mem_addr", 64'(mem_addr), 64'(em.addr));
          if (!em.rw) check("mem_wdata", 64'(mem_wdata), 64'(em.wdata));
        end
      end
      if (tx_start) begin
        txs_count++;
        if (first_txs_cyc < 0) first_txs_cyc = cyc;
        last_tx_mode = tx_mode;
        last_tx_byte = tx_byte;
        last_tx_word = tx_word;
        check("tx_start_while_tx_busy", 64'(tx_busy), 64'd0);
        if (exp_tx.size() == 0) check("tx_unexpected", 64'(tx_start), 64'd0);
        else begin
          et = exp_tx.pop_front();
          check("tx_mode", 64'(tx_mode), 64'(et.mode));
          if (et.mode) check("tx_word", 64'(tx_word), 64'(et.w));
          else         check("tx_byte", 64'(tx_byte), 64'(et.b));
          cur     = et;
          tx_busy = 1;
          tx_cnt  = $urandom_range(0, 4);
        end
      end
    end
  end

  int cmd_cyc;

  task automatic send_cmd(input logic [7:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [1:0] e, input bit dut_busy);
    @(negedge sys_clk);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_addr = a; cmd_data = d; cmd_error = e;
    cmd_cyc = cyc;
    first_men_cyc = -1;
    first_txs_cyc = -1;
    if (dut_busy) m_ovr = 1;
    else model_cmd(op, a, d, e);
    @(negedge sys_clk);
    cmd_valid = 1'b0; cmd_opcode = 8'($urandom); cmd_addr = AW'($urandom);
    cmd_data = $urandom; cmd_error = 2'($urandom);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_mem.size() != 0 || exp_tx.size() != 0 || tx_busy) && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    check({tag, "_timeout"}, 64'(n >= 2000), 64'd0);
    repeat (3) @(negedge sys_clk);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mem_enable"}, 64'(mem_enable), 64'd0);
    check({tag, "_mem_rw"},     64'(mem_rw),     64'd0);
    check({tag, "_mem_addr"},   64'(mem_addr),   64'd0);
    check({tag, "_mem_wdata"},  64'(mem_wdata),  64'd0);
    check({tag, "_tx_start"},   64'(tx_start),   64'd0);
    check({tag, "_tx_mode"},    64'(tx_mode),    64'd0);
    check({tag, "_tx_byte"},    64'(tx_byte),    64'd0);
    check({tag, "_tx_word"},    64'(tx_word),    64'd0);
    check({tag, "_busy"},       64'(busy),       64'd0);
  endtask

  int sel, n, men0, txs0;
  logic [7:0] r_op;
  logic [AW-1:0] r_a;
  logic [DW-1:0] r_d;
  logic [1:0] r_e;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i]    = $urandom;
      ref_mem[i] = sram[i];
    end
    sw_0 = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_addr = '0; cmd_data = '0; cmd_error = '0;
    #2 sw_0 = 1'b0;
    #1 check_quiet("reset");
    repeat (3) @(negedge sys_clk);
    sw_0 = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Write with ack.
    send_cmd(8'h00, 15'h0010, 32'hDEADBEEF, 2'b00, 0);
    drain("write");
    check("write_ack", {55'd0, last_tx_mode, last_tx_byte}, 64'h006);
    check("write_sram", 64'(sram[15'h0010]), 64'hDEADBEEF);

    // Single read and its fixed latency.
    send_cmd(8'h01, 15'h0010, 32'h0, 2'b00, 0);
    drain("read");
    check("read_men_lat", 64'(first_men_cyc - cmd_cyc), 64'd2);
    check("read_tx_lat", 64'(first_txs_cyc - cmd_cyc), 64'(3 + LAT));
    check("read_word", {31'd0, last_tx_mode, last_tx_word}, {31'd0, 1'b1, 32'hDEADBEEF});

    // Burst across the top of the address space.
    seen_addr.delete();
    send_cmd(8'h02, 15'h7FFE, 32'h3, 2'b00, 0);
    drain("burst");
    check("burst_beats", 64'(seen_addr.size()), 64'd3);
    if (seen_addr.size() == 3) begin
      check("burst_addr0", 64'(seen_addr[0]), 64'h7FFE);
      check("burst_addr1", 64'(seen_addr[1]), 64'h7FFF);
      check("burst_addr2", 64'(seen_addr[2]), 64'h0000);
    end

    // Error responses issue no memory access.
    men0 = men_count;
    send_cmd(8'h01, 15'h0020, 32'h0, 2'b10, 0);
    drain("dec_err");
    check("dec_err_byte", {55'd0, last_tx_mode, last_tx_byte}, 64'h002);
    send_cmd(8'h7F, 15'h0020, 32'h0, 2'b00, 0);
    drain("bad_op");
    check("bad_op_byte", 64'(last_tx_byte), 64'h04);
    send_cmd(8'h02, 15'h0020, 32'h0, 2'b00, 0);
    drain("len0");
    check("len0_byte", 64'(last_tx_byte), 64'h04);
    send_cmd(8'h02, 15'h0020, 32'h11, 2'b00, 0);
    drain("len17");
    check("len17_byte", 64'(last_tx_byte), 64'h04);
    check("err_no_mem", 64'(men_count - men0), 64'd0);

    // Overrun during a burst: the burst is untouched, the next command reports 0x05.
    seen_addr.delete();
    send_cmd(8'h02, 15'h0100, 32'h3, 2'b00, 0);
    send_cmd(8'h00, 15'h0200, 32'h12345678, 2'b00, 1);
    drain("ovr_burst");
    check("ovr_burst_beats", 64'(seen_addr.size()), 64'd3);
    check("ovr_not_written", 64'(sram[15'h0200]), 64'(ref_mem[15'h0200]));
    send_cmd(8'h01, 15'h0010, 32'h0, 2'b00, 0);
    drain("ovr_rsp");
    check("ovr_byte", {55'd0, last_tx_mode, last_tx_byte}, 64'h005);

    // Reset while waiting on the transmitter in a burst.
    tx_auto = 0;
    send_cmd(8'h02, 15'h0300, 32'h4, 2'b00, 0);
    n = 0;
    while (exp_tx.size() == 4 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    check("rst_first_tx_timeout", 64'(n >= 200), 64'd0);
    @(negedge sys_clk);
    #2 sw_0 = 1'b0;
    #1 check_quiet("midrst");
    exp_mem.delete();
    exp_tx.delete();
    m_ovr = 0;
    repeat (2) @(negedge sys_clk);
    sw_0 = 1'b1;
    men0 = men_count;
    txs0 = txs_count;
    @(negedge sys_clk) force_done = 1;
    @(negedge sys_clk) force_done = 0;
    repeat (20) @(negedge sys_clk);
    check("midrst_no_tx", 64'(txs_count - txs0), 64'd0);
    check("midrst_no_mem", 64'(men_count - men0), 64'd0);
    check("midrst_idle", 64'(busy), 64'd0);
    tx_auto = 1;

    // Randomized command mix with occasional overruns.
    for (int k = 0; k < 60; k++) begin
      sel  = $urandom_range(0, 9);
      r_op = (sel < 3) ? 8'h00 : (sel < 6) ? 8'h01 : (sel < 9) ? 8'h02 : 8'($urandom_range(3, 255));
      r_a  = ($urandom_range(0, 3) == 0) ? AW'(15'h7FF0 + 15'($urandom_range(0, 15))) : AW'($urandom);
      r_d  = $urandom;
      if (r_op == 8'h02) r_d[7:0] = 8'($urandom_range(0, 18));
      r_e  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      send_cmd(r_op, r_a, r_d, r_e, 0);
      if ($urandom_range(0, 5) == 0)
        send_cmd(8'($urandom), AW'($urandom), $urandom, 2'($urandom), 1);
      drain("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
